dmem_req_sequencer: RTL and testbench

Sequences one outstanding data-memory access from the EXE stage to the dcache port. Owns the dcache request handshake, response tag matching, NACK retry, exception capture and pipeline kill. It exposes a busy/stall flag so the control unit can hold EXE while an access is in flight. It sits between the EXE load/store unit and the `req_cpu_dcache`/`req_dcache_cpu` signal bundles.

---
 rtl/dmem_req_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_dmem_req_sequencer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_req_sequencer.sv
// Single-outstanding data-memory access sequencer between the EXE load/store unit and the dcache port.
// Optional response watchdog is enabled by defining DMEM_SEQ_TIMEOUT_EN.
module dmem_req_sequencer #(
  parameter int ADDR_W      = 40,
  parameter int TAG_W       = 8,
  parameter int MAX_RETRY   = 7,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [63:0]       req_data_i,
  input  logic [1:0]        req_size_i,
  input  logic              kill_i,
  output logic              busy_o,
  output logic              dmem_req_valid_o,
  input  logic              dmem_req_ready_i,
  output logic              dmem_req_cmd_o,
  output logic [ADDR_W-1:0] dmem_req_addr_o,
  output logic [63:0]       dmem_req_data_o,
  output logic [1:0]        dmem_op_type_o,
  output logic [TAG_W-1:0]  dmem_req_tag_o,
  output logic              dmem_req_kill_o,
  input  logic              dmem_resp_valid_i,
  input  logic              dmem_resp_nack_i,
  input  logic [TAG_W-1:0]  dmem_resp_tag_i,
  input  logic [63:0]       dmem_resp_data_i,
  input  logic              dmem_xcpt_ma_i,
  input  logic              dmem_xcpt_pf_i,
  output logic              done_valid_o,
  output logic [1:0]        done_status_o,
  output logic [63:0]       done_data_o,
  output logic [3:0]        xcpt_cause_o
);

  localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(MAX_RETRY);
  localparam logic [RC_W-1:0]  RC_ONE  = {{(RC_W-1){1'b0}}, 1'b1};
  localparam logic [TAG_W-1:0] TAG_ONE = {{(TAG_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_XCPT  = 2'b01;
  localparam logic [1:0] ST_RETRY = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RETRY = 2'd3
  } state_t;

  state_t            state_r, state_next_s;
  logic [TAG_W-1:0]  tag_r, tag_next_s;
  logic [RC_W-1:0]   retry_r, retry_next_s;
  logic              accept_s;
  logic              kill_next_s;
  logic              done_next_s;
  logic [1:0]        status_next_s;
  logic [63:0]       data_next_s;
  logic [3:0]        cause_next_s;
  logic              resp_tag_hit_s;
  logic              xcpt_hit_s;
  logic              nack_hit_s;
  logic              resp_hit_s;

  // Misaligned outranks page fault; the command picks the load or store code.
  function automatic logic [3:0] xcpt_code(input logic store, input logic ma);
    logic [3:0] code;
    case ({store, ma})
      2'b01:   code = 4'd4;
      2'b11:   code = 4'd6;
      2'b00:   code = 4'd13;
      2'b10:   code = 4'd15;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

`ifdef DMEM_SEQ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
  logic [WD_W-1:0] wdog_r, wdog_next_s;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_CYC;
`endif

  assign req_ready_o    = (state_r == S_IDLE) && !kill_i;
  assign busy_o         = (state_r != S_IDLE);
  assign dmem_req_tag_o = tag_r;

  assign resp_tag_hit_s = (dmem_resp_tag_i == tag_r);
  assign xcpt_hit_s     = resp_tag_hit_s && (dmem_xcpt_ma_i || dmem_xcpt_pf_i);
  assign nack_hit_s     = resp_tag_hit_s && dmem_resp_nack_i;
  assign resp_hit_s     = resp_tag_hit_s && dmem_resp_valid_i;

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_next_s  = state_r;
    tag_next_s    = tag_r;
    retry_next_s  = retry_r;
    accept_s      = 1'b0;
    kill_next_s   = 1'b0;
    done_next_s   = 1'b0;
    status_next_s = done_status_o;
    data_next_s   = done_data_o;
    cause_next_s  = xcpt_cause_o;
`ifdef DMEM_SEQ_TIMEOUT_EN
    wdog_next_s   = wdog_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (req_valid_i && !kill_i) begin
          accept_s     = 1'b1;
          state_next_s = S_ISSUE;
          tag_next_s   = tag_r + TAG_ONE;
          retry_next_s = {RC_W{1'b0}};
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        // The dcache has not taken anything yet, so a flush needs no kill pulse.
        if (kill_i) begin
          state_next_s = S_IDLE;
        end else if (dmem_req_ready_i) begin
          state_next_s = S_WAIT;
`ifdef DMEM_SEQ_TIMEOUT_EN
          wdog_next_s  = {WD_W{1'b0}};
`endif
        end else begin
          state_next_s = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (kill_i) begin
          kill_next_s  = 1'b1;
          tag_next_s   = tag_r + TAG_ONE;
          state_next_s = S_IDLE;
        end else if (xcpt_hit_s) begin
          done_next_s   = 1'b1;
          status_next_s = ST_XCPT;
          data_next_s   = 64'd0;
          cause_next_s  = xcpt_code(dmem_req_cmd_o, dmem_xcpt_ma_i);
          state_next_s  = S_IDLE;
        end else if (nack_hit_s) begin
          if (retry_r < RC_MAX) begin
            retry_next_s = retry_r + RC_ONE;
            state_next_s = S_RETRY;
          end else begin
            done_next_s   = 1'b1;
            status_next_s = ST_RETRY;
            data_next_s   = 64'd0;
            cause_next_s  = 4'd0;
            state_next_s  = S_IDLE;
          end
        end else if (resp_hit_s) begin
          done_next_s   = 1'b1;
          status_next_s = ST_OK;
          data_next_s   = dmem_req_cmd_o ? 64'd0 : dmem_resp_data_i;
          cause_next_s  = 4'd0;
          state_next_s  = S_IDLE;
`ifdef DMEM_SEQ_TIMEOUT_EN
        end else if (wdog_r == WD_LAST) begin
          // Watchdog expiry abandons the request under a fresh tag and counts as a retry.
          kill_next_s = 1'b1;
          tag_next_s  = tag_r + TAG_ONE;
          if (retry_r < RC_MAX) begin
            retry_next_s = retry_r + RC_ONE;
            state_next_s = S_RETRY;
          end else begin
            done_next_s   = 1'b1;
            status_next_s = ST_RETRY;
            data_next_s   = 64'd0;
            cause_next_s  = 4'd0;
            state_next_s  = S_IDLE;
          end
        end else begin
          wdog_next_s  = wdog_r + WD_ONE;
          state_next_s = S_WAIT;
        end
`else
        end else begin
          state_next_s = S_WAIT;
        end
`endif
      end
      S_RETRY: begin
        if (kill_i) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_ISSUE;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State, counters, latched request fields and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r          <= S_IDLE;
      tag_r            <= {TAG_W{1'b0}};
      retry_r          <= {RC_W{1'b0}};
      dmem_req_valid_o <= 1'b0;
      dmem_req_cmd_o   <= 1'b0;
      dmem_req_addr_o  <= {ADDR_W{1'b0}};
      dmem_req_data_o  <= 64'd0;
      dmem_op_type_o   <= 2'b00;
      dmem_req_kill_o  <= 1'b0;
      done_valid_o     <= 1'b0;
      done_status_o    <= 2'b00;
      done_data_o      <= 64'd0;
      xcpt_cause_o     <= 4'd0;
`ifdef DMEM_SEQ_TIMEOUT_EN
      wdog_r           <= {WD_W{1'b0}};
`endif
    end else begin
      state_r          <= state_next_s;
      tag_r            <= tag_next_s;
      retry_r          <= retry_next_s;
      dmem_req_valid_o <= (state_next_s == S_ISSUE);
      dmem_req_kill_o  <= kill_next_s;
      done_valid_o     <= done_next_s;
      done_status_o    <= status_next_s;
      done_data_o      <= data_next_s;
      xcpt_cause_o     <= cause_next_s;
`ifdef DMEM_SEQ_TIMEOUT_EN
      wdog_r           <= wdog_next_s;
`endif
      if (accept_s) begin
        dmem_req_cmd_o  <= req_store_i;
        dmem_req_addr_o <= req_addr_i;
        dmem_req_data_o <= req_data_i;
        dmem_op_type_o  <= req_size_i;
      end else begin
        dmem_req_cmd_o  <= dmem_req_cmd_o;
        dmem_req_addr_o <= dmem_req_addr_o;
        dmem_req_data_o <= dmem_req_data_o;
        dmem_op_type_o  <= dmem_op_type_o;
      end
    end
  end

endmodule

// File: tb/tb_dmem_req_sequencer.sv
// Scoreboard bench for dmem_req_sequencer: expected completions are queued as responses are
// driven and popped by a monitor when done_valid_o fires; scenario tasks check handshakes inline.
module tb_dmem_req_sequencer;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_store_i = 1'b0;
  logic [39:0] req_addr_i = 40'd0;
  logic [63:0] req_data_i = 64'd0;
  logic [1:0]  req_size_i = 2'b00;
  logic        kill_i = 1'b0;
  logic        busy_o;
  logic        dmem_req_valid_o;
  logic        dmem_req_ready_i = 1'b0;
  logic        dmem_req_cmd_o;
  logic [39:0] dmem_req_addr_o;
  logic [63:0] dmem_req_data_o;
  logic [1:0]  dmem_op_type_o;
  logic [7:0]  dmem_req_tag_o;
  logic        dmem_req_kill_o;
  logic        dmem_resp_valid_i = 1'b0;
  logic        dmem_resp_nack_i = 1'b0;
  logic [7:0]  dmem_resp_tag_i = 8'd0;
  logic [63:0] dmem_resp_data_i = 64'd0;
  logic        dmem_xcpt_ma_i = 1'b0;
  logic        dmem_xcpt_pf_i = 1'b0;
  logic        done_valid_o;
  logic [1:0]  done_status_o;
  logic [63:0] done_data_o;
  logic [3:0]  xcpt_cause_o;

  dmem_req_sequencer #(
    .ADDR_W(40), .TAG_W(8), .MAX_RETRY(7), .TIMEOUT_CYC(TB_TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_size_i(req_size_i),
    .kill_i(kill_i), .busy_o(busy_o),
    .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
    .dmem_req_cmd_o(dmem_req_cmd_o), .dmem_req_addr_o(dmem_req_addr_o),
    .dmem_req_data_o(dmem_req_data_o), .dmem_op_type_o(dmem_op_type_o),
    .dmem_req_tag_o(dmem_req_tag_o), .dmem_req_kill_o(dmem_req_kill_o),
    .dmem_resp_valid_i(dmem_resp_valid_i), .dmem_resp_nack_i(dmem_resp_nack_i),
    .dmem_resp_tag_i(dmem_resp_tag_i), .dmem_resp_data_i(dmem_resp_data_i),
    .dmem_xcpt_ma_i(dmem_xcpt_ma_i), .dmem_xcpt_pf_i(dmem_xcpt_pf_i),
    .done_valid_o(done_valid_o), .done_status_o(done_status_o),
    .done_data_o(done_data_o), .xcpt_cause_o(xcpt_cause_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  status;
    logic [63:0] data;
    logic [3:0]  cause;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  int         hs_cnt = 0;
  int         kill_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] hs_tag_last = 8'd0;
  logic [7:0] exp_tag = 8'd0;

  // Completion monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (dmem_req_kill_o) kill_cnt++;
    if (done_valid_o) begin
      done_cnt++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done got status=%b data=%h, required no completion", done_status_o, done_data_o);
      end else begin
        mon_e = sb_q.pop_front();
        if (done_status_o !== mon_e.status ||
            (mon_e.status == 2'b00 && done_data_o !== mon_e.data) ||
            (mon_e.status == 2'b01 && xcpt_cause_o !== mon_e.cause)) begin
          n_fail++;
          $display("FAIL done_result got status=%b data=%h cause=%0d, required status=%b data=%h cause=%0d",
                   done_status_o, done_data_o, xcpt_cause_o, mon_e.status, mon_e.data, mon_e.cause);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic accept(input logic st, input logic [39:0] a, input logic [63:0] d, input logic [1:0] sz);
    req_valid_i = 1'b1;
    req_store_i = st;
    req_addr_i  = a;
    req_data_i  = d;
    req_size_i  = sz;
    tick();
    req_valid_i = 1'b0;
    exp_tag     = exp_tag + 8'd1;
  endtask

  task automatic handshake();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (dmem_req_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_wait got no dmem_req_valid_o within 16 cycles, required a request");
    end else begin
      dmem_req_ready_i = 1'b1;
      hs_tag_last = dmem_req_tag_o;
      hs_cnt++;
      tick();
      dmem_req_ready_i = 1'b0;
    end
  endtask

  task automatic respond(input logic v, input logic n, input logic ma, input logic pf,
                         input logic [7:0] t, input logic [63:0] d);
    dmem_resp_valid_i = v;
    dmem_resp_nack_i  = n;
    dmem_xcpt_ma_i    = ma;
    dmem_xcpt_pf_i    = pf;
    dmem_resp_tag_i   = t;
    dmem_resp_data_i  = d;
    tick();
    dmem_resp_valid_i = 1'b0;
    dmem_resp_nack_i  = 1'b0;
    dmem_xcpt_ma_i    = 1'b0;
    dmem_xcpt_pf_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    exp_tag = 8'd0;
    n_checks++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_busy got ready=%b busy=%b, required 1 0", req_ready_o, busy_o);
    end
    n_checks++;
    if (dmem_req_valid_o !== 1'b0 || dmem_req_kill_o !== 1'b0 || dmem_req_tag_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_req got valid=%b kill=%b tag=%h, required 0 0 00", dmem_req_valid_o, dmem_req_kill_o, dmem_req_tag_o);
    end
    n_checks++;
    if (done_valid_o !== 1'b0 || done_status_o !== 2'b00 || done_data_o !== 64'd0 || xcpt_cause_o !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_done got valid=%b status=%b data=%h cause=%0d, required zeros", done_valid_o, done_status_o, done_data_o, xcpt_cause_o);
    end
    kill_i = 1'b1;
    #1;
    n_checks++;
    if (req_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_kill got %b, required 0", req_ready_o);
    end
    kill_i = 1'b0;
    #1;
  endtask

  task automatic test_load();
    accept(1'b0, 40'h80000010, 64'h0, 2'b11);
    n_checks++;
    if (dmem_req_valid_o !== 1'b1 || dmem_req_tag_o !== 8'd1 || dmem_req_addr_o !== 40'h80000010 ||
        dmem_req_cmd_o !== 1'b0 || dmem_op_type_o !== 2'b11 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL load_issue got valid=%b tag=%h addr=%h cmd=%b size=%b busy=%b, required 1 01 80000010 0 11 1",
               dmem_req_valid_o, dmem_req_tag_o, dmem_req_addr_o, dmem_req_cmd_o, dmem_op_type_o, busy_o);
    end
    dmem_req_ready_i = 1'b1;
    tick();
    dmem_req_ready_i = 1'b0;
    sb_q.push_back('{status: 2'b00, data: 64'hDEADBEEF, cause: 4'd0});
    respond(1'b1, 1'b0, 1'b0, 1'b0, exp_tag, 64'hDEADBEEF);
    n_checks++;
    if (done_valid_o !== 1'b1 || done_data_o !== 64'hDEADBEEF || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_latency got done=%b data=%h busy=%b at cycle 3, required 1 deadbeef 0", done_valid_o, done_data_o, busy_o);
    end
    tick();
    n_checks++;
    if (done_valid_o !== 1'b0 || done_data_o !== 64'hDEADBEEF) begin
      n_fail++;
      $display("FAIL done_pulse got done=%b data=%h, required 0 deadbeef", done_valid_o, done_data_o);
    end
  endtask

  task automatic test_store_nack();
    hs_cnt = 0;
    accept(1'b1, 40'h00001238, 64'h1122334455667788, 2'b10);
    n_checks++;
    if (dmem_req_cmd_o !== 1'b1 || dmem_req_data_o !== 64'h1122334455667788) begin
      n_fail++;
      $display("FAIL store_latch got cmd=%b data=%h, required 1 1122334455667788", dmem_req_cmd_o, dmem_req_data_o);
    end
    for (int i = 0; i < 3; i++) begin
      handshake();
      n_checks++;
      if (hs_tag_last !== exp_tag) begin
        n_fail++;
        $display("FAIL store_tag got %h, required %h", hs_tag_last, exp_tag);
      end
      if (i < 2) begin
        respond(1'b0, 1'b1, 1'b0, 1'b0, exp_tag, 64'h0);
        n_checks++;
        if (dmem_req_valid_o !== 1'b0 || busy_o !== 1'b1) begin
          n_fail++;
          $display("FAIL retry_bubble got valid=%b busy=%b, required 0 1", dmem_req_valid_o, busy_o);
        end
      end else begin
        sb_q.push_back('{status: 2'b00, data: 64'd0, cause: 4'd0});
        respond(1'b1, 1'b0, 1'b0, 1'b0, exp_tag, 64'hFFFF0000FFFF0000);
      end
    end
    n_checks++;
    if (hs_cnt !== 3) begin
      n_fail++;
      $display("FAIL store_handshakes got %0d, required 3", hs_cnt);
    end
  endtask

  task automatic test_retry_exhaust();
    hs_cnt = 0;
    accept(1'b0, 40'h0000004000, 64'h0, 2'b11);
    for (int i = 0; i < 8; i++) begin
      handshake();
      if (i == 7) sb_q.push_back('{status: 2'b10, data: 64'd0, cause: 4'd0});
      respond(1'b0, 1'b1, 1'b0, 1'b0, exp_tag, 64'h0);
    end
    n_checks++;
    if (hs_cnt !== 8 || busy_o !== 1'b0 || done_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL retry_exhaust got issues=%0d busy=%b done=%b, required 8 0 1", hs_cnt, busy_o, done_valid_o);
    end
  endtask

  task automatic test_exception();
    logic [1:0] flags [4] = '{2'b11, 2'b11, 2'b01, 2'b01};
    logic       st    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] cause [4] = '{4'd4, 4'd6, 4'd13, 4'd15};
    for (int i = 0; i < 4; i++) begin
      accept(st[i], 40'h0000000101, 64'h55, 2'b01);
      handshake();
      sb_q.push_back('{status: 2'b01, data: 64'd0, cause: cause[i]});
      respond(1'b1, 1'b1, flags[i][1], flags[i][0], exp_tag, 64'h99);
      n_checks++;
      if (done_valid_o !== 1'b1 || done_status_o !== 2'b01 || xcpt_cause_o !== cause[i]) begin
        n_fail++;
        $display("FAIL exception_%0d got done=%b status=%b cause=%0d, required 1 01 %0d", i, done_valid_o, done_status_o, xcpt_cause_o, cause[i]);
      end
    end
  endtask

  task automatic test_kill();
    int         k0;
    int         d0;
    logic [7:0] old_tag;
    accept(1'b0, 40'h0000002000, 64'h0, 2'b11);
    handshake();
    k0 = kill_cnt;
    d0 = done_cnt;
    old_tag = exp_tag;
    kill_i = 1'b1;
    respond(1'b1, 1'b0, 1'b0, 1'b0, old_tag, 64'h1234);
    kill_i = 1'b0;
    exp_tag = exp_tag + 8'd1;
    n_checks++;
    if (dmem_req_kill_o !== 1'b1 || busy_o !== 1'b0 || done_valid_o !== 1'b0 || dmem_req_tag_o !== exp_tag) begin
      n_fail++;
      $display("FAIL kill_wait got kill=%b busy=%b done=%b tag=%h, required 1 0 0 %h", dmem_req_kill_o, busy_o, done_valid_o, dmem_req_tag_o, exp_tag);
    end
    tick();
    respond(1'b1, 1'b0, 1'b0, 1'b0, old_tag, 64'h1234);
    tick();
    n_checks++;
    if (kill_cnt !== k0 + 1 || done_cnt !== d0 || dmem_req_kill_o !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_stale got kills=%0d dones=%0d, required %0d %0d", kill_cnt - k0, done_cnt - d0, 1, 0);
    end
  endtask

  task automatic test_ignored_resp();
    int d0;
    d0 = done_cnt;
    accept(1'b0, 40'h0000003000, 64'h0, 2'b10);
    respond(1'b1, 1'b0, 1'b0, 1'b0, exp_tag, 64'hAAAA);
    n_checks++;
    if (dmem_req_valid_o !== 1'b1 || busy_o !== 1'b1 || done_cnt !== d0) begin
      n_fail++;
      $display("FAIL issue_resp_ignored got valid=%b busy=%b dones=%0d, required 1 1 0", dmem_req_valid_o, busy_o, done_cnt - d0);
    end
    handshake();
    respond(1'b1, 1'b0, 1'b1, 1'b1, exp_tag + 8'd1, 64'hBBBB);
    n_checks++;
    if (busy_o !== 1'b1 || done_cnt !== d0) begin
      n_fail++;
      $display("FAIL tag_mismatch got busy=%b dones=%0d, required 1 0", busy_o, done_cnt - d0);
    end
    sb_q.push_back('{status: 2'b00, data: 64'hCCCC, cause: 4'd0});
    respond(1'b1, 1'b0, 1'b0, 1'b0, exp_tag, 64'hCCCC);
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    logic        st;
    for (int i = 0; i < 260; i++) begin
      d  = {$urandom, $urandom};
      st = ($urandom_range(0, 3) == 0);
      accept(st, {8'h00, $urandom}, d, 2'b11);
      n_checks++;
      if (dmem_req_tag_o !== exp_tag) begin
        n_fail++;
        $display("FAIL b2b_tag got %h, required %h", dmem_req_tag_o, exp_tag);
      end
      handshake();
      sb_q.push_back('{status: 2'b00, data: st ? 64'd0 : d, cause: 4'd0});
      respond(1'b1, 1'b0, 1'b0, 1'b0, exp_tag, d);
    end
  endtask

`ifdef DMEM_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int wait_cyc;
    wait_cyc = -1;
    accept(1'b0, 40'h0000005000, 64'h0, 2'b11);
    handshake();
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (dmem_req_kill_o === 1'b1) begin
        wait_cyc = i;
        break;
      end
    end
    exp_tag = exp_tag + 8'd1;
    n_checks++;
    if (wait_cyc !== TB_TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout_kill got kill after %0d cycles, required %0d", wait_cyc, TB_TIMEOUT);
    end
    handshake();
    n_checks++;
    if (hs_tag_last !== exp_tag) begin
      n_fail++;
      $display("FAIL timeout_tag got %h, required %h", hs_tag_last, exp_tag);
    end
    sb_q.push_back('{status: 2'b00, data: 64'h7777, cause: 4'd0});
    respond(1'b1, 1'b0, 1'b0, 1'b0, exp_tag, 64'h7777);
  endtask
`endif

  task automatic test_reset_mid();
    int k0;
    int d0;
    accept(1'b0, 40'h0000006000, 64'h0, 2'b11);
    handshake();
    k0 = kill_cnt;
    d0 = done_cnt;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_tag = 8'd0;
    n_checks++;
    if (busy_o !== 1'b0 || dmem_req_tag_o !== 8'd0 || dmem_req_kill_o !== 1'b0 || done_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got busy=%b tag=%h kill=%b done=%b, required 0 00 0 0", busy_o, dmem_req_tag_o, dmem_req_kill_o, done_valid_o);
    end
    tick();
    n_checks++;
    if (kill_cnt !== k0 || done_cnt !== d0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet got kills=%0d dones=%0d, required 0 0", kill_cnt - k0, done_cnt - d0);
    end
    accept(1'b0, 40'h0000006008, 64'h0, 2'b11);
    n_checks++;
    if (dmem_req_tag_o !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_mid_tag got %h, required 01", dmem_req_tag_o);
    end
    handshake();
    sb_q.push_back('{status: 2'b00, data: 64'h4242, cause: 4'd0});
    respond(1'b1, 1'b0, 1'b0, 1'b0, exp_tag, 64'h4242);
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_nack();
    test_retry_exhaust();
    test_exception();
    test_kill();
    test_ignored_resp();
    test_back_to_back();
`ifdef DMEM_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    tick();
    tick();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending completions, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
